// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length header, then big-endian 16-bit words written to IMEM.
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
   parameter int MEM_DEPTH  = 4096,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_en,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_din,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_LEN_HI  = 4'd1;
   localparam logic [3:0] S_LEN_LO  = 4'd2;
   localparam logic [3:0] S_DATA_HI = 4'd3;
   localparam logic [3:0] S_DATA_LO = 4'd4;
   localparam logic [3:0] S_WRITE   = 4'd5;
   localparam logic [3:0] S_DONE    = 4'd6;
   localparam logic [3:0] S_ERR     = 4'd7;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [3:0] S_CSUM    = 4'd8;
   localparam logic [3:0] S_FIN     = S_CSUM;
`else
   localparam logic [3:0] S_FIN     = S_DONE;
`endif

   logic [3:0]            state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            lo_q, lo_d;
   logic                  accept;
   logic [15:0]           len_rx;
   logic [ADDR_WIDTH-1:0] last_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   assign len_rx   = {hi_q, in_data};
   // len_q never exceeds MEM_DEPTH in a data phase, so N-1 always fits the counter width.
   assign last_idx = ADDR_WIDTH'(len_q - 16'd1);
   assign accept   = in_valid && in_ready;

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      unique case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
`endif
         S_WRITE: busy = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN_HI;
               cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               hi_d    = in_data;
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d = len_rx;
               if (len_rx == 16'd0)
                  state_d = S_FIN;
               else if (32'(len_rx) > MEM_DEPTH)
                  state_d = S_ERR;
               else
                  state_d = S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               hi_d    = in_data;
               state_d = S_DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ in_data;
`endif
            end
         end
         S_DATA_LO: begin
            if (accept) begin
               lo_d    = in_data;
               state_d = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ in_data;
`endif
            end
         end
         S_WRITE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == last_idx) ? S_FIN : S_DATA_HI;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept)
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         cnt_q   <= '0;
         hi_q    <= 8'h00;
         lo_q    <= 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign mem_en    = (state_q == S_WRITE);
   assign mem_wr_en = (state_q == S_WRITE);
   assign mem_rd_en = 1'b0;
   assign mem_addr  = cnt_q;
   assign mem_din   = {hi_q, lo_q};
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   // The CPU is released only after a fully verified load.
   assign cpu_hold  = (state_q != S_DONE);

endmodule
